polar_lookahead_decider: RTL and testbench
==========================================

Name:
polar_lookahead_decider

Overview:
Sequential successor to the combinational 2-bit look-ahead decision node used in the SC decoder datapath. Per frame it:
- latches an N-bit frozen mask;
- accepts N/2 LLR pairs over a valid/ready stream;
- makes the 2-bit look-ahead decision (u2i, u2i+1) for each pair;
- emits per-pair partial sums;
- assembles the decided frame for hand-off to the downstream partial-sum/output stage.

Parameters:
N, 16, frame length in bits; power of two, 4..1024.
LLR_W, 8, LLR width, two's complement.
CNT_W, $clog2(N)+1, width of the info-bit count.

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active-high.
frz_valid  in  1  frozen mask offered.
frz_ready  out  1  mask accepted when high with frz_valid.
frz_mask  in  N  bit k=1 means u_k frozen.
llr_valid  in  1  LLR pair offered.
llr_ready  out  1  pair accepted when high with llr_valid.
llr_a  in  LLR_W  LLR for the f-decision (upper branch).
llr_b  in  LLR_W  LLR for the g-decision (lower branch).
ps_valid  out  1  one-cycle pulse: per-pair partial sum valid.
ps_out  out  2  {u2i+1, u2i^u2i+1}, i.e. bit1=u1, bit0=u0^u1.
frm_valid  out  1  decided frame available.
frm_ready  in  1  downstream accepts the frame.
u_hat  out  N  decided bits; bit 2k=u0 of pair k, bit 2k+1=u1 of pair k.
info_cnt  out  CNT_W  number of unfrozen bits set to 1 in u_hat.

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous, active-high.
- Reset values: state=IDLE, frz_ready=1, llr_ready=0, ps_valid=0, ps_out=0, frm_valid=0, u_hat=0, info_cnt=0, pair counter=0, mask register=0.
- Decision rule for pair k, with a=llr_a, b=llr_b, f0=mask[2k], f1=mask[2k+1], and h(x)=1 iff x<0:
  - u0 = f0 ? 0 : h(a)^h(b).
  - g = b + a if u0=0, else b - a. Computed sign-extended to LLR_W+1 bits, so it cannot overflow.
  - u1 = f1 ? 0 : h(g). g=0 gives u1=0.
- Frozen forcing of u0 takes effect before g is computed: g always uses the forced u0.
- States:
  - IDLE: frz_ready=1, llr_ready=0. On frz_valid, latch the mask, clear u_hat, info_cnt and the pair counter, then go to COLLECT. llr_valid is ignored in IDLE.
  - COLLECT: frz_ready=0, llr_ready=1. On each accepted pair, in the next cycle:
    - write u_hat[2k+1:2k];
    - add u0+u1 to info_cnt;
    - pulse ps_valid with ps_out;
    - increment k.
    - After pair N/2-1 is accepted, go to DONE.
  - DONE: frm_valid=1, llr_ready=0, frz_ready=0. u_hat and info_cnt hold stable. When frm_valid&frm_ready, return to IDLE in the next cycle; frz_ready=1 from that cycle.
- Latency: pair accepted at cycle t → ps_valid/u_hat update at t+1. Last pair at t → frm_valid at t+1.
- Throughput: one pair per cycle; a frame takes N/2 cycles plus one handshake cycle back to IDLE.
- llr_valid gaps: allowed anywhere in COLLECT. The counter advances only on accepted beats.
- Backpressure: frm_ready low holds DONE indefinitely. No further mask or LLR is accepted during that time.
- rst mid-frame: the partial frame is discarded, all outputs return to reset values, and no ps_valid pulse is emitted for a beat accepted in the reset cycle.
- Only u_hat bits of already-decided pairs are meaningful before DONE. Undecided bits read 0.

Optional Feature:
Macro POLAR_LA_PIPE_EN.
- Defined: a register stage is inserted between the pair input and the decision logic (a, b, f0, f1 registered).
  - ps_valid/u_hat update move to t+2; frm_valid asserts at t+2 after the last pair.
  - llr_ready stays 1 for every cycle in COLLECT; the pipeline flushes before DONE.
  - rst clears the pipeline register.
- Undefined: the decision is combinational from the accepted beat; latency is as stated above.

Test Plan:
1. Mask 0xFFFF, 8 arbitrary pairs → u_hat=0x0000, info_cnt=0, every ps_out=2'b00, frm_valid 1 cycle after the 8th accept.
2. Mask 0x0000; pair0 a=+5,b=-3 → u0=1, g=-8, u1=1, ps_out=2'b10. Pair1 a=-10,b=+3 → u0=1, g=13, u1=0, ps_out=2'b01. u_hat[3:0]=4'b0111.
3. Width extremes, mask 0: a=-128,b=-128 → u0=0, g=-256, u1=1. a=-128,b=+127 → u0=1, g=255, u1=0. a=0,b=0 → u0=0, u1=0.
4. Frozen interaction: mask bit0=1, bit1=0; a=+4,b=-4 → u0 forced 0, g=0, u1=0. Repeat with mask bit0=0 → u0=1, g=-8, u1=1.
5. Flow control: random llr_valid gaps and frm_ready held low 20 cycles → llr_ready=0 and frz_ready=0 throughout DONE; u_hat stable; after accept, frz_ready=1 the next cycle.
6. rst asserted after 3 pairs, then a fresh frame → outputs return to reset values; the new frame's u_hat and info_cnt match the reference model, with no residue from the aborted frame. Rerun scenarios 1–6 with POLAR_LA_PIPE_EN defined and check the +1 latency.

Source files
------------

// File: rtl/polar_lookahead_decider_if.sv
// polar_lookahead_decider_if: mask, LLR-pair, partial-sum and decided-frame channels of the look-ahead decider.
interface polar_lookahead_decider_if #(
  parameter int N = 16,
  parameter int LLR_W = 8,
  parameter int CNT_W = $clog2(N) + 1
);
  logic frz_valid;
  logic frz_ready;
  logic [N-1:0] frz_mask;
  logic llr_valid;
  logic llr_ready;
  logic [LLR_W-1:0] llr_a;
  logic [LLR_W-1:0] llr_b;
  logic ps_valid;
  logic [1:0] ps_out;
  logic frm_valid;
  logic frm_ready;
  logic [N-1:0] u_hat;
  logic [CNT_W-1:0] info_cnt;
  modport master (
    output frz_valid, frz_mask, llr_valid, llr_a, llr_b, frm_ready,
    input frz_ready, llr_ready, ps_valid, ps_out, frm_valid, u_hat, info_cnt
  );
  modport slave (
    input frz_valid, frz_mask, llr_valid, llr_a, llr_b, frm_ready,
    output frz_ready, llr_ready, ps_valid, ps_out, frm_valid, u_hat, info_cnt
  );
endinterface

// File: rtl/polar_lookahead_decider.sv
// polar_lookahead_decider: sequential 2-bit look-ahead SC decision node; POLAR_LA_PIPE_EN registers each pair before deciding.
module polar_lookahead_decider #(
  parameter int N = 16,
  parameter int LLR_W = 8,
  parameter int CNT_W = $clog2(N) + 1
) (
  input logic clk,
  input logic rst,
  polar_lookahead_decider_if.slave bus
);
  localparam int KW = $clog2(N) - 1;
  localparam logic [KW-1:0] LAST = KW'(N / 2 - 1);
  localparam logic [1:0] IDLE = 2'd0, COLLECT = 2'd1, DONE = 2'd2, FLUSH = 2'd3;
  logic [1:0] state;
  logic [N-1:0] mask;
  logic [KW-1:0] k;
  logic acc;
  logic dv, f0, f1, u0, u1;
  logic [LLR_W-1:0] da, db;
  logic [KW-1:0] dk;
  logic [LLR_W:0] ae, be, g;
  assign acc = state == COLLECT && bus.llr_valid;
  assign bus.frz_ready = state == IDLE;
  assign bus.llr_ready = state == COLLECT;
  assign bus.frm_valid = state == DONE;
`ifdef POLAR_LA_PIPE_EN
  localparam logic [1:0] AFTER_LAST = FLUSH;
  logic pv, pf0, pf1;
  logic [LLR_W-1:0] pa, pb;
  logic [KW-1:0] pk;
  always_ff @(posedge clk) begin
    if (rst) begin
      pv <= 1'b0;
      pa <= '0;
      pb <= '0;
      pf0 <= 1'b0;
      pf1 <= 1'b0;
      pk <= '0;
    end else begin
      pv <= acc;
      if (acc) begin
        pa <= bus.llr_a;
        pb <= bus.llr_b;
        pf0 <= mask[{k, 1'b0}];
        pf1 <= mask[{k, 1'b1}];
        pk <= k;
      end
    end
  end
  assign {dv, da, db, dk, f0, f1} = {pv, pa, pb, pk, pf0, pf1};
`else
  localparam logic [1:0] AFTER_LAST = DONE;
  assign {dv, da, db, dk, f0, f1} = {acc, bus.llr_a, bus.llr_b, k, mask[{k, 1'b0}], mask[{k, 1'b1}]};
`endif
  // g is formed one bit wider than the LLRs so b+/-a never wraps
  assign ae = {da[LLR_W-1], da};
  assign be = {db[LLR_W-1], db};
  assign u0 = ~f0 & (da[LLR_W-1] ^ db[LLR_W-1]);
  assign g = u0 ? be - ae : be + ae;
  assign u1 = ~f1 & g[LLR_W];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mask <= '0;
      k <= '0;
      bus.u_hat <= '0;
      bus.info_cnt <= '0;
      bus.ps_valid <= 1'b0;
      bus.ps_out <= '0;
    end else begin
      bus.ps_valid <= dv;
      if (dv) begin
        bus.ps_out <= {u1, u0 ^ u1};
        bus.u_hat[{dk, 1'b0} +: 2] <= {u1, u0};
        bus.info_cnt <= bus.info_cnt + CNT_W'(u0) + CNT_W'(u1);
      end
      if (state == IDLE && bus.frz_valid) begin
        mask <= bus.frz_mask;
        k <= '0;
        bus.u_hat <= '0;
        bus.info_cnt <= '0;
        state <= COLLECT;
      end
      if (acc) begin
        k <= k + 1'b1;
        if (k == LAST) state <= AFTER_LAST;
      end
      if (state == FLUSH) state <= DONE;
      if (state == DONE && bus.frm_ready) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_polar_lookahead_decider.sv
// tb_polar_lookahead_decider: randomized scoreboard bench for the look-ahead decider against an integer reference model.
module tb_polar_lookahead_decider;
  localparam int N = 16;
  localparam int LLR_W = 8;
  localparam int NP = N / 2;
`ifdef POLAR_LA_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  typedef struct { logic [1:0] ps; int t; } ps_t;
  typedef struct { logic [N-1:0] u; int cnt; int t; } fr_t;
  logic clk = 0;
  logic rst;
  int cyc = 0;
  int errs = 0;
  int checks = 0;
  ps_t ps_q[$];
  fr_t fr_q[$];
  logic [N-1:0] cur_mask, cur_u;
  int pidx;
  bit gaps;
  int va[NP], vb[NP];
  logic fv_prev = 0;
  polar_lookahead_decider_if #(.N(N), .LLR_W(LLR_W)) bus ();
  polar_lookahead_decider #(.N(N), .LLR_W(LLR_W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction
  // Reference decision with plain integer arithmetic: returns {u1,u0}
  function automatic logic [1:0] decide(input logic fr0, input logic fr1, input int a, input int b);
    int gv;
    logic x0, x1;
    x0 = !fr0 && ((a < 0) != (b < 0));
    gv = x0 ? b - a : b + a;
    x1 = !fr1 && (gv < 0);
    return {x1, x0};
  endfunction
  always @(negedge clk) begin
    if (bus.ps_valid) begin
      if (ps_q.size() == 0) check("ps_unexpected", 1, 0);
      else begin
        ps_t e;
        e = ps_q.pop_front();
        check("ps_out", bus.ps_out, e.ps);
        check("ps_latency", cyc, e.t + LAT);
      end
    end
    if (bus.frm_valid && !fv_prev) begin
      if (fr_q.size() == 0) check("frm_unexpected", 1, 0);
      else begin
        fr_t f;
        f = fr_q.pop_front();
        check("u_hat", bus.u_hat, f.u);
        check("info_cnt", bus.info_cnt, f.cnt);
        check("frm_latency", cyc, f.t + LAT);
      end
    end
    fv_prev = bus.frm_valid;
  end
  task automatic check_reset();
    check("rst_frz_ready", bus.frz_ready, 1);
    check("rst_llr_ready", bus.llr_ready, 0);
    check("rst_ps_valid", bus.ps_valid, 0);
    check("rst_ps_out", bus.ps_out, 0);
    check("rst_frm_valid", bus.frm_valid, 0);
    check("rst_u_hat", bus.u_hat, 0);
    check("rst_info_cnt", bus.info_cnt, 0);
  endtask
  task automatic send_mask(input logic [N-1:0] m);
    int t = 0;
    bus.frz_valid = 1;
    bus.frz_mask = m;
    while (!bus.frz_ready && t < 200) begin @(negedge clk); t++; end
    check("mask_timeout", t < 200, 1);
    cur_mask = m;
    cur_u = '0;
    pidx = 0;
    @(negedge clk);
    bus.frz_valid = 0;
    bus.frz_mask = N'($urandom);
  endtask
  task automatic send_pair(input int a, input int b);
    int t = 0;
    logic [1:0] u;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    bus.llr_valid = 1;
    bus.llr_a = LLR_W'(a);
    bus.llr_b = LLR_W'(b);
    while (!bus.llr_ready && t < 200) begin @(negedge clk); t++; end
    check("pair_timeout", t < 200, 1);
    u = decide(cur_mask[2 * pidx], cur_mask[2 * pidx + 1], a, b);
    ps_q.push_back('{ps: {u[1], u[0] ^ u[1]}, t: cyc});
    cur_u[2 * pidx +: 2] = u;
    pidx++;
    if (pidx == NP) fr_q.push_back('{u: cur_u, cnt: $countones(cur_u), t: cyc});
    @(negedge clk);
    bus.llr_valid = 0;
    bus.llr_a = LLR_W'($urandom);
    bus.llr_b = LLR_W'($urandom);
  endtask
  task automatic finish_frame(input int hold);
    int t = 0;
    while (!bus.frm_valid && t < 50) begin @(negedge clk); t++; end
    check("frm_timeout", bus.frm_valid, 1);
    bus.llr_valid = 1;
    bus.frz_valid = 1;
    repeat (hold) begin
      check("done_llr_ready", bus.llr_ready, 0);
      check("done_frz_ready", bus.frz_ready, 0);
      check("done_u_hat", bus.u_hat, cur_u);
      @(negedge clk);
    end
    bus.llr_valid = 0;
    bus.frz_valid = 0;
    bus.frm_ready = 1;
    @(negedge clk);
    bus.frm_ready = 0;
    check("idle_frz_ready", bus.frz_ready, 1);
    check("idle_frm_valid", bus.frm_valid, 0);
  endtask
  task automatic rand_pairs();
    for (int i = 0; i < NP; i++) begin
      va[i] = int'($urandom_range(0, 255)) - 128;
      vb[i] = int'($urandom_range(0, 255)) - 128;
    end
  endtask
  task automatic run_frame(input logic [N-1:0] m, input int hold);
    send_mask(m);
    for (int i = 0; i < NP; i++) send_pair(va[i], vb[i]);
    finish_frame(hold);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1;
    gaps = 0;
    bus.frz_valid = 0;
    bus.frz_mask = '0;
    bus.llr_valid = 0;
    bus.llr_a = '0;
    bus.llr_b = '0;
    bus.frm_ready = 0;
    repeat (3) @(negedge clk);
    check_reset();
    rst = 0;
    rand_pairs();
    run_frame(16'hFFFF, 0);
    rand_pairs();
    va[0] = 5; vb[0] = -3; va[1] = -10; vb[1] = 3;
    run_frame(16'h0000, 0);
    rand_pairs();
    va[0] = -128; vb[0] = -128; va[1] = -128; vb[1] = 127; va[2] = 0; vb[2] = 0;
    run_frame(16'h0000, 1);
    rand_pairs();
    va[0] = 4; vb[0] = -4;
    run_frame(16'h0001, 0);
    va[0] = 4; vb[0] = -4;
    run_frame(16'h0000, 0);
    gaps = 1;
    rand_pairs();
    run_frame(N'($urandom), 20);
    send_mask(N'($urandom));
    for (int i = 0; i < 3; i++) send_pair(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
    repeat (3) @(negedge clk);
    bus.llr_valid = 1;
    bus.llr_a = 8'h85;
    bus.llr_b = 8'h13;
    rst = 1;
    @(negedge clk);
    rst = 0;
    bus.llr_valid = 0;
    check_reset();
    rand_pairs();
    run_frame(N'($urandom), 2);
    for (int f = 0; f < 10; f++) begin
      gaps = f[0];
      rand_pairs();
      run_frame(N'($urandom), $urandom_range(0, 3));
    end
    repeat (5) @(negedge clk);
    check("ps_queue_drained", ps_q.size(), 0);
    check("frm_queue_drained", fr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
